oam_dma: RTL

Bus-master DMA engine placed between the 6502 core and the system bus. It performs sprite DMA on a CPU write to $4014 by copying 256 bytes from page `$XX00–$XXFF` to $2004. It also services single-byte DMC sample fetches for the APU. While it owns the bus it asserts `pause`, and the top level uses that to gate the CPU's `ce`.

---
 rtl/oam_dma.sv | 133 +++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// Bus-master DMA: 256-byte sprite copy from page $XX00 to $2004 on a $4014 write,
// plus single-byte DMC sample fetches. pause tells the top level to gate the CPU.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mw,
  input  logic [7:0]  din,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        pause,
  output logic [15:0] dma_aout,
  output logic [7:0]  dma_dout,
  output logic        dma_mr,
  output logic        dma_mw,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data
);
  // state     | meaning
  // IDLE      | CPU owns the bus
  // HALT      | first paused cycle, bus idle
  // ALIGN     | idle odd cycle so the following read lands on an even cycle
  // READ      | read {page,cnt} into dataByte
  // WRITE     | write dataByte to $2004
  // DMC_DUMMY | idle cycle ahead of a standalone DMC fetch
  // DMC_READ  | read dmc_addr and hand the byte to the APU
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HALT      = 3'd1;
  localparam logic [2:0] ALIGN     = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] DMC_DUMMY = 3'd5;
  localparam logic [2:0] DMC_READ  = 3'd6;

  logic [2:0] state;
  logic       odd;
  logic [7:0] page;
  logic [7:0] cnt;
  logic       oamPend;
  logic [7:0] dataByte;
  logic       trigger;
  logic       dmcReq;

  assign trigger = cpu_mw && (cpu_aout == 16'h4014);
  // A requester drops dmc_req on seeing dmc_ack; ignoring it during the ack
  // cycle keeps the same sample from being fetched twice.
  assign dmcReq  = dmc_req && !dmc_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      odd      <= 1'b0;
      page     <= 8'h00;
      cnt      <= 8'h00;
      oamPend  <= 1'b0;
      dataByte <= 8'h00;
      dmc_ack  <= 1'b0;
      dmc_data <= 8'h00;
    end else if (ce) begin
      odd     <= ~odd;
      dmc_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            page    <= cpu_dout;
            cnt     <= 8'h00;
            oamPend <= 1'b1;
            state   <= HALT;
          end else if (dmcReq) begin
            oamPend <= 1'b0;
            state   <= HALT;
          end
        end
        HALT: begin
          if (!oamPend)
            state <= DMC_DUMMY;
          else if (odd)
            state <= dmcReq ? DMC_READ : READ;
          else
            state <= ALIGN;
        end
        DMC_DUMMY: state <= odd ? DMC_READ : ALIGN;
        ALIGN: begin
          if (dmcReq)
            state <= DMC_READ;
          else if (oamPend)
            state <= READ;
          else
            state <= IDLE;
        end
        READ: begin
          dataByte <= din;
          state    <= WRITE;
        end
        WRITE: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) begin
            oamPend <= 1'b0;
            state   <= dmcReq ? DMC_READ : IDLE;
          end else begin
            state   <= dmcReq ? DMC_READ : READ;
          end
        end
        DMC_READ: begin
          dmc_data <= din;
          dmc_ack  <= 1'b1;
          state    <= oamPend ? ALIGN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pause  = (state != IDLE);
  assign dma_mr = (state == READ) || (state == DMC_READ);
  assign dma_mw = (state == WRITE);

  always_comb begin
    dma_aout = 16'h0000;
    dma_dout = 8'h00;
    case (state)
      READ:     dma_aout = {page, cnt};
      WRITE: begin
        dma_aout = 16'h2004;
        dma_dout = dataByte;
      end
      DMC_READ: dma_aout = dmc_addr;
      default:  dma_aout = 16'h0000;
    endcase
  end
endmodule
